// File: rtl/mult_booth.sv
`default_nettype none
// ============================================================================
// Module   : mult_booth
// Purpose  : Sequential signed 32x32 multiplier using radix-4 Booth recoding
//            (16 steps). Returns product[31:0] and flags signed overflow of
//            the 32-bit result. Shares the divider's start/result/ready/
//            exception handshake so the multdiv wrapper can mux both units.
// Ports    : clock          - rising-edge clock
//            reset_n        - asynchronous active-low reset
//            data_operandA  - multiplicand (two's complement), sampled on start
//            data_operandB  - multiplier (two's complement), sampled on start
//            ctrl_MULT      - start strobe; restarts even while busy
//            data_result    - product[31:0], held until next completion
//            data_exception - product does not fit in signed 32 bits
//            data_resultRDY - one-cycle pulse when data_result becomes valid
// Config   : MULT_EARLY_TERM_EN - finish as soon as the remaining multiplier
//            bits are all-0 or all-1 (remaining Booth digits are zero).
// Revision : 1.0 - initial release
// ============================================================================
module mult_booth (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_LAST_STEP = 4'd15;

  state_t      r_st,     w_st_next;
  logic [63:0] r_m,      w_m_next;
  logic [32:0] r_q,      w_q_next;
  logic [63:0] r_p,      w_p_next;
  logic [3:0]  r_cnt,    w_cnt_next;
  logic [31:0] r_result, w_result_next;
  logic        r_exc,    w_exc_next;
  logic        r_rdy,    w_rdy_next;

  logic [63:0] w_addend;
  logic [63:0] w_m2;
  logic [63:0] w_p_step;
  logic [63:0] w_m_step;
  logic [32:0] w_q_step;
  logic        w_last;
  logic        w_ovf;

  // One Booth step: the digit is selected from Q[2:0], M carries the weight
  // 4^i, and Q is shifted arithmetically so the sign of B keeps feeding in.
  assign w_m2     = {r_m[62:0], 1'b0};
  assign w_p_step = r_p + w_addend;
  assign w_m_step = {r_m[61:0], 2'b00};
  assign w_q_step = {{2{r_q[32]}}, r_q[32:2]};

  always_comb begin
    w_addend = 64'd0;
    case (r_q[2:0])
      3'b001, 3'b010: w_addend = r_m;
      3'b011:         w_addend = w_m2;
      3'b100:         w_addend = ~w_m2 + 64'd1;
      3'b101, 3'b110: w_addend = ~r_m + 64'd1;
      default:        w_addend = 64'd0;
    endcase
  end

`ifdef MULT_EARLY_TERM_EN
  // Once the remaining multiplier bits are uniform every later digit is 0,
  // so the accumulator already holds the final product.
  assign w_last = (r_cnt == c_LAST_STEP) || (w_q_step == 33'd0) || (&w_q_step);
`else
  assign w_last = (r_cnt == c_LAST_STEP);
`endif

  // Result fits in signed 32 bits only if bits 63..31 are a pure sign extension.
  assign w_ovf = ~((&w_p_step[63:31]) | ~(|w_p_step[63:31]));

  always_comb begin
    w_st_next     = r_st;
    w_m_next      = r_m;
    w_q_next      = r_q;
    w_p_next      = r_p;
    w_cnt_next    = r_cnt;
    w_result_next = r_result;
    w_exc_next    = r_exc;
    w_rdy_next    = 1'b0;
    if (ctrl_MULT) begin
      // A start always wins, including over a step that would terminate.
      w_m_next   = {{32{data_operandA[31]}}, data_operandA};
      w_q_next   = {data_operandB, 1'b0};
      w_p_next   = 64'd0;
      w_cnt_next = 4'd0;
      w_st_next  = ST_BUSY;
    end else begin
      case (r_st)
        ST_BUSY: begin
          w_p_next   = w_p_step;
          w_m_next   = w_m_step;
          w_q_next   = w_q_step;
          w_cnt_next = r_cnt + 4'd1;
          if (w_last) begin
            w_st_next     = ST_DONE;
            w_result_next = w_p_step[31:0];
            w_exc_next    = w_ovf;
            w_rdy_next    = 1'b1;
          end
        end
        ST_DONE: w_st_next = ST_IDLE;
        default: w_st_next = r_st;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_st     <= ST_IDLE;
      r_m      <= 64'd0;
      r_q      <= 33'd0;
      r_p      <= 64'd0;
      r_cnt    <= 4'd0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_st     <= w_st_next;
      r_m      <= w_m_next;
      r_q      <= w_q_next;
      r_p      <= w_p_next;
      r_cnt    <= w_cnt_next;
      r_result <= w_result_next;
      r_exc    <= w_exc_next;
      r_rdy    <= w_rdy_next;
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule
`default_nettype wire
